// File: rtl/mips_pkg.sv
// Shared loader definitions: FSM state encoding and byte/word geometry of the
// instruction-memory write path.
package mips_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = WORD_BYTES * BYTE_W;
  localparam int BCNT_W     = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DONE    = 3'd4
  } ld_state_e;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word packer: the first byte of a word lands in the top byte.
// word_full flags the shift that completes a word.
module byte_packer
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BCNT_W-1:0] cnt_q, cnt_d;

  // Next shift-register contents and byte count.
  always_comb begin
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    word_full = shift_en && (cnt_q == BCNT_W'(WORD_BYTES - 1));
    if (clr) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shreg_d = {shreg_q[WORD_W-BYTE_W-1:0], byte_in};
      cnt_d   = cnt_q + BCNT_W'(1);
    end else begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word = shreg_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory program loader: packs a byte stream into words and writes
// them to consecutive addresses. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam ld_state_e LAST_ST = ST_CHECK;
`else
  localparam ld_state_e LAST_ST = ST_DONE;
`endif

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              rx_ready_q, rx_ready_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pack_clr;
  logic              byte_take;
  logic              shift_en;
  logic              word_full;

  assign byte_take = rx_valid && rx_ready_q;
  assign shift_en  = byte_take && (state_q == ST_COLLECT);

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst),
    .clr       (pack_clr),
    .shift_en  (shift_en),
    .byte_in   (rx_data),
    .word      (mem_wdata),
    .word_full (word_full)
  );

  // Next-state logic; outputs are decoded from the next state so they come out of flops.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    pack_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          rem_d    = word_count;
          pack_clr = 1'b1;
          state_d  = (word_count == '0) ? LAST_ST : ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (word_full) state_d = ST_WRITE;
        else           state_d = ST_COLLECT;
      end
      ST_WRITE: begin
        if (mem_gnt) begin
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - CNT_W'(1);
          state_d = (rem_q == CNT_W'(1)) ? LAST_ST : ST_COLLECT;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_CHECK: begin
        if (byte_take) state_d = ST_DONE;
        else           state_d = ST_CHECK;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    rx_ready_d = (state_d == ST_COLLECT) || (state_d == ST_CHECK);
    mem_we_d   = (state_d == ST_WRITE);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      rx_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      rx_ready_q <= rx_ready_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
  logic              err_q, err_d;

  // Running XOR over data bytes; the trailing byte in CHECK is compared against it.
  always_comb begin
    csum_d = csum_q;
    err_d  = err_q;
    if (pack_clr) begin
      csum_d = '0;
      err_d  = 1'b0;
    end else if (shift_en) begin
      csum_d = csum_q ^ rx_data;
    end else if ((state_q == ST_CHECK) && byte_take) begin
      err_d = (rx_data != csum_q);
    end else begin
      csum_d = csum_q;
    end
  end

  // Checksum accumulator and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else begin
      csum_q <= csum_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign rx_ready = rx_ready_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = addr_q;
  assign cpu_hold = busy_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed sessions plus randomized ones,
// checked against a word/address list and XOR derived from the byte stream.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 9;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_gnt = 1'b0;
  logic              cpu_hold, busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  stim[$];
  logic [39:0] obs_q[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err)
  );

  // Record every accepted memory write.
  always @(posedge clk)
    if (rst && mem_we && mem_gnt) obs_q.push_back({mem_addr, mem_wdata});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xsum(input int cnt);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 4 * cnt; i++) x ^= stim[i];
    return x;
  endfunction

  task automatic run_session(input logic [7:0] base, input int cnt, input int gnt_low,
                             input int gap_pct, input logic [7:0] csum);
    logic [7:0]  bytes[$];
    logic [39:0] exp_q[$];
    logic        exp_err;
    logic        prev_we, prev_gnt, fin;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0] prev_data;
    int idx, n, done_seen, busy_cyc, we_cyc, nw;
    for (int w = 0; w < cnt; w++) begin
      logic [31:0] word;
      word = {stim[4*w], stim[4*w+1], stim[4*w+2], stim[4*w+3]};
      exp_q.push_back({8'(int'(base) + w), word});
      for (int k = 0; k < 4; k++) bytes.push_back(stim[4*w+k]);
    end
    exp_err = (CS == 1) && (csum != xsum(cnt));
    if (CS == 1) bytes.push_back(csum);
    n = bytes.size();
    obs_q.delete();

    @(negedge clk);
    start = 1'b1; base_addr = base; word_count = CNT_W'(cnt);
    @(negedge clk);
    start = 1'b0; base_addr = 8'($urandom); word_count = CNT_W'($urandom);
    chk("hold_after_start", cpu_hold, 1);
    chk("busy_after_start", busy, 1);
    chk("err_cleared", err, 0);
    chk("ready_after_start", rx_ready, (cnt > 0) || (CS == 1));

    idx = 0; done_seen = 0; busy_cyc = 0; we_cyc = 0; fin = 1'b0;
    prev_we = 1'b0; prev_gnt = 1'b0; prev_addr = '0; prev_data = '0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      if (prev_we && !prev_gnt) begin
        chk("stall_we", mem_we, 1);
        chk("stall_addr", mem_addr, prev_addr);
        chk("stall_data", mem_wdata, prev_data);
      end
      if (mem_we) chk("ready_in_write", rx_ready, 0);
      if (done) done_seen++;
      if (!busy) begin
        fin = 1'b1;
      end else begin
        busy_cyc++;
        start  = ($urandom_range(3) == 0);
        we_cyc = mem_we ? we_cyc + 1 : 0;
        mem_gnt = (gnt_low < 0) ? ($urandom_range(1) == 1) : (mem_we && (we_cyc > gnt_low));
        if (idx < n) begin
          if ($urandom_range(99) >= gap_pct) begin
            rx_valid = 1'b1; rx_data = bytes[idx];
            if (rx_ready) idx++;
          end else begin
            rx_valid = 1'b0; rx_data = 8'($urandom);
          end
        end else begin
          rx_valid = ($urandom_range(1) == 1); rx_data = 8'($urandom);
        end
        prev_we = mem_we; prev_gnt = mem_gnt; prev_addr = mem_addr; prev_data = mem_wdata;
        @(negedge clk);
      end
    end
    start = 1'b0; rx_valid = 1'b0; mem_gnt = 1'b0;

    chk("session_timeout", fin, 1);
    chk("done_pulses", done_seen, 1);
    chk("bytes_taken", idx, n);
    chk("hold_released", cpu_hold, 0);
    if (gnt_low == 0 && gap_pct == 0) chk("busy_cycles", busy_cyc, 5 * cnt + 1 + CS);
    chk("n_writes", obs_q.size(), exp_q.size());
    nw = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < nw; i++) chk("write_addr_data", obs_q[i], exp_q[i]);
    chk("err_flag", err, exp_err);
  endtask

  initial begin
    #2;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Reference program, immediate grant.
    stim = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h42, 8'h00, 8'h01};
    run_session(8'h10, 2, 0, 0, xsum(2));

    // Grant withheld for 6 cycles.
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(8'($urandom));
    run_session(8'h20, 1, 6, 0, xsum(1));

    // Address wrap.
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
    run_session(8'hFF, 2, 0, 0, xsum(2));

    // Reset after two bytes of the first word.
    obs_q.delete();
    @(negedge clk);
    start = 1'b1; base_addr = 8'h33; word_count = CNT_W'(3);
    @(negedge clk);
    start = 1'b0; rx_valid = 1'b1; rx_data = 8'hA1;
    @(negedge clk);
    rx_data = 8'hB2;
    @(negedge clk);
    rst = 1'b0; rx_valid = 1'b1; mem_gnt = 1'b1;
    #1;
    chk("mid_rst_rx_ready", rx_ready, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_mem_wdata", mem_wdata, 0);
    chk("mid_rst_cpu_hold", cpu_hold, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    chk("no_write_after_rst", obs_q.size(), 0);
    chk("idle_after_rst", busy, 0);
    rx_valid = 1'b0; mem_gnt = 1'b0;
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
    run_session(8'h40, 2, 0, 0, xsum(2));

    // Zero-length sessions.
    stim.delete();
    run_session(8'h50, 0, 0, 0, 8'h00);
    run_session(8'h50, 0, 0, 0, 8'h5A);

    // Checksum good, then bad and sticky.
    stim = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_session(8'h60, 1, 0, 0, 8'h04);
    run_session(8'h60, 1, 0, 0, 8'h05);
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("err_sticky", err, CS);

    // Randomized sessions.
    for (int s = 0; s < 10; s++) begin
      int cnt;
      logic [7:0] cs;
      cnt = $urandom_range(4, 1);
      stim.delete();
      for (int i = 0; i < 4 * cnt; i++) stim.push_back(8'($urandom));
      cs = ($urandom_range(1) == 1) ? xsum(cnt) : 8'($urandom);
      run_session(8'($urandom), cnt, int'($urandom_range(4)) - 1, 30, cs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
